load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 256: max cycles spent in REQ+WAIT before the access is aborted.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req_valid  input  1  core presents a load/store this cycle.
REQ-005 mem_write  input  1  1 = store, 0 = load.
REQ-006 data_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-007 extension_type  input  1  loads: 0 sign-extend, 1 zero-extend.
REQ-008 addr  input  32  byte address from ALU.
REQ-009 store_data  input  32  rs2 value, right-justified.
REQ-010 stall  output  1  freeze PC/regfile while high.
REQ-011 load_data  output  32  extended load result, valid with load_valid.
REQ-012 load_valid  output  1  one-cycle pulse: load_data valid, regfile may write.
REQ-013 err  output  1  one-cycle pulse: misaligned, reserved size or timeout.
REQ-014 bus_req_valid / bus_req_ready  output / input  1 / 1  request handshake.
REQ-015 bus_we, bus_addr[31:0], bus_wdata[31:0], bus_wstrb[3:0]  outputs  request payload; bus_addr word-aligned (addr[1:0] forced 00).
REQ-016 bus_rsp_valid / bus_rdata[31:0]  inputs  response (read data or write ack).

Function
REQ-017 FSM states IDLE, REQ, WAIT, DONE.
REQ-018 IDLE: on req_valid with legal size/alignment, latch mem_write, data_size, extension_type, addr, store_data; go REQ.
REQ-019 Illegal access (size 11; half with addr[0]=1; word with addr[1:0]!=00): no bus request; go DONE with err flag set.
REQ-020 REQ: bus_req_valid=1, payload held stable from latched values; on bus_req_valid & bus_req_ready go WAIT.
REQ-021 WAIT: bus_req_valid=0; on bus_rsp_valid capture bus_rdata (loads), go DONE.
REQ-022 DONE: lasts exactly one cycle, stall=0; load_valid=1 for successful loads; err=1 if flagged; then IDLE; req_valid ignored in DONE.
REQ-023 stall = (IDLE & req_valid) | REQ | WAIT, combinational; minimum legal access = 3 stall cycles.
REQ-024 Store strobes: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
REQ-025 Store wdata: byte replicated to all 4 lanes; half replicated to both halves; word unchanged.
REQ-026 Load extract: byte lane addr[1:0], half lane addr[1]; extend to 32 bits per extension_type; word unchanged.
REQ-027 Timeout counter clears on IDLE->REQ, increments each REQ/WAIT cycle; on reaching TIMEOUT_CYCLES go DONE with err=1, load_valid=0, load_data=0.
REQ-028 bus_rsp_valid outside WAIT is ignored; simultaneous bus_rsp_valid and timeout expiry: response wins.
REQ-029 load_data holds last value outside DONE.

Reset
REQ-030 rst_n=0 at an edge: state IDLE, counter 0, stall follows REQ-023, bus_req_valid=0, load_valid=0, err=0, load_data=0, bus_addr/bus_wdata/bus_wstrb=0, bus_we=0.
REQ-031 Reset mid-REQ/WAIT abandons the access with no load_valid or err; subsequent stale bus_rsp_valid is ignored.

Structure
REQ-032 Shared package riscv_pkg holds data_size encodings (SIZE_B, SIZE_H, SIZE_W) and the LSU state enum.
REQ-033 One combinational sub-module lsu_align performs strobe/wdata steering and load extraction/extension; FSM and counter stay in load_store_unit.

Verification
REQ-034 LB addr 0x1003, bus_rdata 0x80123456, extension_type 0 -> bus_addr 0x1000, load_data 0xFFFFFF80, load_valid one cycle.
REQ-035 Same with extension_type 1 (LBU) -> load_data 0x00000080.
REQ-036 SH addr 0x2002, store_data 0x1234ABCD -> bus_we=1, bus_addr 0x2000, bus_wstrb 1100, bus_wdata 0xABCDABCD; no load_valid.
REQ-037 LW addr 0x3001 -> err pulse, bus_req_valid never high, stall high exactly one cycle.
REQ-038 bus_req_ready held 0 for TIMEOUT_CYCLES -> err pulse, load_data 0, FSM back to IDLE.
REQ-039 rst_n=0 during WAIT, then bus_rsp_valid -> no load_valid, no err, state IDLE.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the load/store unit: access-size encodings, LSU FSM
// states, the bus request payload and the alignment legality check.
package riscv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned STRB_W = XLEN / 8;

  // data_size encodings
  localparam logic [1:0] SIZE_B   = 2'b00;
  localparam logic [1:0] SIZE_H   = 2'b01;
  localparam logic [1:0] SIZE_W   = 2'b10;
  localparam logic [1:0] SIZE_RSV = 2'b11;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'b00,
    LSU_REQ  = 2'b01,
    LSU_WAIT = 2'b10,
    LSU_DONE = 2'b11
  } lsu_state_e;

  // Payload held stable on the bus for the whole request phase
  typedef struct packed {
    logic              we;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
    logic [STRB_W-1:0] wstrb;
  } bus_req_t;

  // Natural alignment: halves on even addresses, words on multiples of 4
  function automatic logic access_legal(input logic [1:0] size, input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    case (size)
      SIZE_B:  ok = 1'b1;
      SIZE_H:  ok = ~addr_lo[0];
      SIZE_W:  ok = (addr_lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Purely combinational lane steering for the LSU.
//   Store side: st_size_i/st_addr_lo_i/st_data_i -> st_wdata_o (replicated
//               lanes) and st_wstrb_o (byte enables).
//   Load side:  ld_size_i/ld_addr_lo_i/ld_zext_i/ld_rdata_i -> ld_data_o
//               (selected lane, sign- or zero-extended).
module lsu_align
  import riscv_pkg::*;
(
  input  logic [1:0]        st_size_i,
  input  logic [1:0]        st_addr_lo_i,
  input  logic [XLEN-1:0]   st_data_i,
  output logic [XLEN-1:0]   st_wdata_o,
  output logic [STRB_W-1:0] st_wstrb_o,
  input  logic [1:0]        ld_size_i,
  input  logic [1:0]        ld_addr_lo_i,
  input  logic              ld_zext_i,
  input  logic [XLEN-1:0]   ld_rdata_i,
  output logic [XLEN-1:0]   ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store steering: replication lets any lane pick up the data, strobes select it
  always_comb begin
    st_wdata_o = '0;
    st_wstrb_o = '0;
    case (st_size_i)
      SIZE_B: begin
        st_wdata_o = {4{st_data_i[7:0]}};
        st_wstrb_o = 4'b0001 << st_addr_lo_i;
      end
      SIZE_H: begin
        st_wdata_o = {2{st_data_i[15:0]}};
        st_wstrb_o = 4'b0011 << st_addr_lo_i;
      end
      SIZE_W: begin
        st_wdata_o = st_data_i;
        st_wstrb_o = 4'b1111;
      end
      default: begin
        st_wdata_o = '0;
        st_wstrb_o = '0;
      end
    endcase
  end

  assign ld_byte = ld_rdata_i[{ld_addr_lo_i, 3'b000} +: 8];
  assign ld_half = ld_rdata_i[{ld_addr_lo_i[1], 4'b0000} +: 16];

  // Load extraction and extension
  always_comb begin
    ld_data_o = '0;
    case (ld_size_i)
      SIZE_B:  ld_data_o = ld_zext_i ? {24'h000000, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SIZE_H:  ld_data_o = ld_zext_i ? {16'h0000, ld_half} : {{16{ld_half[15]}}, ld_half};
      SIZE_W:  ld_data_o = ld_rdata_i;
      default: ld_data_o = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: takes one core access at a time, runs a valid/ready request
// and a response phase on the data bus, and returns extended load data.
//   Core side: req_valid, mem_write, data_size, extension_type, addr,
//              store_data in; stall (combinational), load_data, load_valid,
//              err out.
//   Bus side:  bus_req_valid/bus_req_ready handshake with bus_we, bus_addr
//              (word aligned), bus_wdata, bus_wstrb; bus_rsp_valid/bus_rdata.
// An access stuck in REQ+WAIT for TIMEOUT_CYCLES cycles is aborted with err.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              mem_write,
  input  logic [1:0]        data_size,
  input  logic              extension_type,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   store_data,
  output logic              stall,
  output logic [XLEN-1:0]   load_data,
  output logic              load_valid,
  output logic              err,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic              bus_we,
  output logic [XLEN-1:0]   bus_addr,
  output logic [XLEN-1:0]   bus_wdata,
  output logic [STRB_W-1:0] bus_wstrb,
  input  logic              bus_rsp_valid,
  input  logic [XLEN-1:0]   bus_rdata
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  bus_req_t          req_q, req_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic              zext_q, zext_d;
  logic [XLEN-1:0]   load_data_q, load_data_d;
  logic              load_valid_q, load_valid_d;
  logic              err_q, err_d;

  logic [XLEN-1:0]   st_wdata_c;
  logic [STRB_W-1:0] st_wstrb_c;
  logic [XLEN-1:0]   ld_data_c;
  logic [CNT_W-1:0]  cnt_inc_c;
  logic              timeout_c;

  // Store side steers the incoming access; load side uses the latched one
  lsu_align u_align (
    .st_size_i    (data_size),
    .st_addr_lo_i (addr[1:0]),
    .st_data_i    (store_data),
    .st_wdata_o   (st_wdata_c),
    .st_wstrb_o   (st_wstrb_c),
    .ld_size_i    (size_q),
    .ld_addr_lo_i (addr_lo_q),
    .ld_zext_i    (zext_q),
    .ld_rdata_i   (bus_rdata),
    .ld_data_o    (ld_data_c)
  );

  // This cycle is the TIMEOUT_CYCLES-th one spent in REQ+WAIT
  assign cnt_inc_c = cnt_q + CNT_W'(1);
  assign timeout_c = (cnt_inc_c == CNT_W'(TIMEOUT_CYCLES));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= LSU_IDLE;
      cnt_q        <= '0;
      req_q        <= '0;
      size_q       <= SIZE_B;
      addr_lo_q    <= 2'b00;
      zext_q       <= 1'b0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      size_q       <= size_d;
      addr_lo_q    <= addr_lo_d;
      zext_q       <= zext_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      err_q        <= err_d;
    end
  end

  // Next-state logic; load_valid/err are set on entry to DONE so they pulse there
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    size_d       = size_q;
    addr_lo_d    = addr_lo_q;
    zext_d       = zext_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    err_d        = 1'b0;

    case (state_q)
      LSU_IDLE: begin
        if (req_valid) begin
          if (access_legal(data_size, addr[1:0])) begin
            state_d   = LSU_REQ;
            cnt_d     = '0;
            req_d.we    = mem_write;
            req_d.addr  = {addr[XLEN-1:2], 2'b00};
            req_d.wdata = mem_write ? st_wdata_c : '0;
            req_d.wstrb = mem_write ? st_wstrb_c : '0;
            size_d    = data_size;
            addr_lo_d = addr[1:0];
            zext_d    = extension_type;
          end else begin
            state_d = LSU_DONE;
            err_d   = 1'b1;
          end
        end
      end

      // Timeout beats a handshake on the last allowed cycle: no response could follow
      LSU_REQ: begin
        cnt_d = cnt_inc_c;
        if (timeout_c) begin
          state_d     = LSU_DONE;
          err_d       = 1'b1;
          load_data_d = '0;
        end else if (bus_req_ready) begin
          state_d = LSU_WAIT;
        end
      end

      // A response arriving on the expiry cycle still completes the access
      LSU_WAIT: begin
        cnt_d = cnt_inc_c;
        if (bus_rsp_valid) begin
          state_d = LSU_DONE;
          if (!req_q.we) begin
            load_valid_d = 1'b1;
            load_data_d  = ld_data_c;
          end
        end else if (timeout_c) begin
          state_d     = LSU_DONE;
          err_d       = 1'b1;
          load_data_d = '0;
        end
      end

      LSU_DONE: begin
        state_d = LSU_IDLE;
      end

      default: begin
        state_d = LSU_IDLE;
      end
    endcase
  end

  assign stall         = ((state_q == LSU_IDLE) && req_valid) ||
                         (state_q == LSU_REQ) || (state_q == LSU_WAIT);
  assign bus_req_valid = (state_q == LSU_REQ);
  assign bus_we        = req_q.we;
  assign bus_addr      = req_q.addr;
  assign bus_wdata     = req_q.wdata;
  assign bus_wstrb     = req_q.wstrb;
  assign load_data     = load_data_q;
  assign load_valid    = load_valid_q;
  assign err           = err_q;

endmodule
